data_mem_ctrl: RTL and testbench

- Load/store controller between the single-cycle core's execute stage and a word-wide, wait-stated data SRAM.
- Consumes the ALU effective address, the rs2 store data and the load/store type codes from Control_Unit.
- Drives a req/ack memory port and stalls the core, freezing the PC and suppressing RF write, until the access completes.
- Performs byte-lane steering, write strobes, load sign/zero extension, alignment checking and an ack timeout.

---
 rtl/mem_pkg.sv | 74 +++++++
 rtl/data_mem_ctrl_if.sv | 48 ++++
 rtl/lsu_align.sv | 74 +++++++
 rtl/data_mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory load/store controller.
//
// Contents:
//   load_type_t   - load encodings from Control_Unit (LB, LBU, LH, LHU, LW)
//   store_type_t  - store encodings from Control_Unit (SB, SH, SW)
//   ctrl_state_t  - controller FSM states (IDLE, BUSY, DONE)
//   acc_size_t    - access width after decoding the type code
//   ERR_*         - err_code values reported alongside err
//   load_size / store_size / is_misaligned - decode and alignment helpers
package mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b001,
        LBU = 3'b010,
        LH  = 3'b011,
        LHU = 3'b100,
        LW  = 3'b101
    } load_type_t;

    typedef enum logic [1:0] {
        SB = 2'b01,
        SH = 2'b10,
        SW = 2'b11
    } store_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_RW       = 2'b11;

    // Undefined codes fall back to a full word access.
    function automatic acc_size_t load_size(input logic [2:0] lt);
        acc_size_t sz;
        case (lt)
            LB, LBU: sz = SZ_BYTE;
            LH, LHU: sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic acc_size_t store_size(input logic [1:0] st);
        acc_size_t sz;
        case (st)
            SB:      sz = SZ_BYTE;
            SH:      sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Memory-side port of the load/store controller.
//
// Handshake: the controller raises mem_req together with mem_we, mem_addr,
// mem_wstrb and mem_wdata, and holds all of them stable until the SRAM
// returns a single-cycle mem_ack. The cycle mem_ack is high completes the
// access; mem_rdata is only meaningful in that cycle. The controller drops
// mem_req on the edge that samples mem_ack (or when it gives up after the
// timeout), so one request is matched by at most one ack.
//
// Signals:
//   mem_req   - request, registered, controller -> SRAM
//   mem_we    - 1 = write, 0 = read
//   mem_addr  - word address (byte address without the two low bits)
//   mem_wstrb - per-byte write strobes, 0000 for reads
//   mem_wdata - lane-steered write data
//   mem_rdata - read word, SRAM -> controller, valid with mem_ack
//   mem_ack   - completion pulse, SRAM -> controller
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads. Purely
// combinational.
//
// Ports:
//   st_addr_lo  in  2   byte offset of the store address
//   store_type  in  2   store type code
//   write_data  in  32  raw rs2 value
//   st_wstrb    out 4   byte strobes for the store
//   st_wdata    out 32  store data replicated onto every lane it may land in
//   ld_addr_lo  in  2   byte offset of the latched load address
//   load_type   in  3   latched load type code
//   rdata       in  32  word returned by the SRAM
//   ld_data     out 32  selected and sign/zero-extended load result
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  store_type,
    input  logic [31:0] write_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  load_type,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_signed;

    // Stores: replicate the datum so the SRAM only needs the strobes to
    // pick the right lane; no shifter on the write path.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = write_data;
        case (store_size(store_type))
            SZ_BYTE: begin
                st_wstrb = 4'b0001 << st_addr_lo;
                st_wdata = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                // Misaligned halfwords never reach here, so bit 1 picks the half.
                st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{write_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = write_data;
            end
        endcase
    end

    // Loads: select the addressed byte/half, then extend.
    always_comb begin
        byte_sel = rdata[7:0];
        case (ld_addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        is_signed = (load_type == LB) || (load_type == LH);

        ld_data = rdata;
        case (load_size(load_type))
            SZ_BYTE: ld_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the core's execute stage and a wait-stated,
// word-wide data SRAM. Stalls the core while an access is in flight, checks
// alignment, steers store lanes, extends loads and aborts on a missing ack.
//
// Ports:
//   clk           in   core clock
//   rst           in   asynchronous active-low reset
//   mem_read_en   in   load request
//   mem_write_en  in   store request
//   address       in   byte address (ALU result)
//   write_data    in   raw rs2 value
//   load_type     in   load type code (mem_pkg::load_type_t)
//   store_type    in   store type code (mem_pkg::store_type_t)
//   stall         out  combinational; hold PC, block RF write
//   done          out  one-cycle pulse when the access retires
//   load_data     out  extended load result, valid with done
//   err           out  one-cycle pulse with done on a failed access
//   err_code      out  misaligned / timeout / read+write, valid with err
//   state_dbg     out  current FSM state
//   mem           SRAM port (data_mem_ctrl_if.master)
//
// Timing: request seen in IDLE (stall=1) -> BUSY until ack or timeout ->
// DONE for one cycle (done=1, stall=0, core retires) -> IDLE. Illegal
// requests go straight from IDLE to DONE without touching the SRAM.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic [2:0]        load_type,
    input  logic [1:0]        store_type,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              err,
    output logic [1:0]        err_code,
    output ctrl_state_t       state_dbg,
    data_mem_ctrl_if.master   mem
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    ctrl_state_t        state;
    ctrl_state_t        next_state;
    logic [TIMER_W-1:0] timer;

    logic [1:0]         lat_addr_lo;
    logic [2:0]         lat_load_type;

    logic               any_req;
    logic               both_req;
    acc_size_t          req_size;
    logic               req_misaligned;

    logic               accept;
    logic               reject;
    logic [1:0]         reject_code;
    logic               ack_finish;
    logic               timeout_finish;

    logic [3:0]         st_wstrb;
    logic [31:0]        st_wdata;
    logic [31:0]        ld_ext;

    assign state_dbg = state;

    // Request decode. When both enables are set the size is irrelevant
    // because the read+write error takes priority.
    assign any_req        = mem_read_en | mem_write_en;
    assign both_req       = mem_read_en & mem_write_en;
    assign req_size       = mem_write_en ? store_size(store_type) : load_size(load_type);
    assign req_misaligned = is_misaligned(req_size, address[1:0]);

    lsu_align u_align (
        .st_addr_lo (address[1:0]),
        .store_type (store_type),
        .write_data (write_data),
        .st_wstrb   (st_wstrb),
        .st_wdata   (st_wdata),
        .ld_addr_lo (lat_addr_lo),
        .load_type  (lat_load_type),
        .rdata      (mem.mem_rdata),
        .ld_data    (ld_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, stall and the per-cycle decisions used by the datapath.
    always_comb begin
        next_state     = state;
        stall          = 1'b0;
        accept         = 1'b0;
        reject         = 1'b0;
        reject_code    = ERR_NONE;
        ack_finish     = 1'b0;
        timeout_finish = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    stall = 1'b1;
                    if (both_req) begin
                        reject      = 1'b1;
                        reject_code = ERR_RW;
                        next_state  = DONE;
                    end else if (req_misaligned) begin
                        reject      = 1'b1;
                        reject_code = ERR_MISALIGN;
                        next_state  = DONE;
                    end else begin
                        accept     = 1'b1;
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // Ack wins over an expiring timer in the same cycle.
                if (mem.mem_ack) begin
                    ack_finish = 1'b1;
                    next_state = DONE;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    timeout_finish = 1'b1;
                    next_state     = DONE;
                end
            end
            DONE: begin
                // The core still presents the retiring instruction here,
                // so requests are not looked at.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered outputs, SRAM port, latched access info and BUSY timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= 4'b0000;
            mem.mem_wdata <= 32'd0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            load_data     <= 32'd0;
            timer         <= '0;
            lat_addr_lo   <= 2'b00;
            lat_load_type <= 3'b000;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;

            if (accept) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= mem_write_en;
                mem.mem_addr  <= address[ADDR_W-1:2];
                mem.mem_wstrb <= mem_write_en ? st_wstrb : 4'b0000;
                mem.mem_wdata <= mem_write_en ? st_wdata : 32'd0;
                lat_addr_lo   <= address[1:0];
                lat_load_type <= load_type;
                timer         <= '0;
            end

            if (reject) begin
                done      <= 1'b1;
                err       <= 1'b1;
                err_code  <= reject_code;
                load_data <= 32'd0;
            end

            if (state == BUSY) begin
                timer <= timer + TIMER_W'(1);
            end

            if (ack_finish || timeout_finish) begin
                mem.mem_req   <= 1'b0;
                mem.mem_we    <= 1'b0;
                mem.mem_addr  <= '0;
                mem.mem_wstrb <= 4'b0000;
                mem.mem_wdata <= 32'd0;
                timer         <= '0;
                done          <= 1'b1;
            end

            if (ack_finish) begin
                // mem_we is still the value of the access being acked.
                load_data <= mem.mem_we ? 32'd0 : ld_ext;
            end

            if (timeout_finish) begin
                err       <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                load_data <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [2:0]        ltp;
    logic [1:0]        stp;
    logic              stall;
    logic              done;
    logic [31:0]       load_data;
    logic              err;
    logic [1:0]        err_code;
    ctrl_state_t       state_dbg;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

    data_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_en  (rd),
        .mem_write_en (wr),
        .address      (addr),
        .write_data   (wd),
        .load_type    (ltp),
        .store_type   (stp),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .err          (err),
        .err_code     (err_code),
        .state_dbg    (state_dbg),
        .mem          (mif)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld;
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata;
    logic [29:0] last_maddr;
    logic [1:0]  last_ecode;
    int          last_req_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ld_bytes(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 1;
        if (t == 3'd3 || t == 3'd4) return 2;
        return 4;
    endfunction

    function automatic int st_bytes(input logic [1:0] t);
        if (t == 2'd1) return 1;
        if (t == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [1:0] a,
                                               input logic [31:0] w);
        int          n;
        logic [31:0] v;
        n = ld_bytes(t);
        v = w >> (8 * a);
        if (n == 1) v = v & 32'h0000_00FF;
        if (n == 2) v = v & 32'h0000_FFFF;
        if (t == 3'd1 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
        if (t == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [1:0] t, input logic [1:0] a);
        int m;
        m = ((1 << st_bytes(t)) - 1) << a;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] t, input logic [31:0] d);
        int n;
        n = st_bytes(t);
        if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge with the DUT idle. ack_dly is the
    // number of BUSY cycles before mem_ack; >= TIMEOUT means never.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] lt, input logic [1:0] st,
                          input int ack_dly, input logic [31:0] rword);
        int          n;
        logic        ill;
        logic        tmo;
        logic [1:0]  ecode;
        logic [31:0] exp_ld;
        logic [31:0] got_ld;
        int          req_cycles;
        n     = w ? st_bytes(st) : ld_bytes(lt);
        ill   = (r && w) || ((a & 32'(n - 1)) != 0);
        tmo   = !ill && (ack_dly >= TIMEOUT);
        ecode = (r && w) ? 2'b11 : ill ? 2'b01 : tmo ? 2'b10 : 2'b00;
        exp_ld = (ill || tmo || w) ? 32'd0 : model_load(lt, a[1:0], rword);
        exp_q.push_back(exp_ld);
        req_cycles = 0;

        rd = r; wr = w; addr = a; wd = d; ltp = lt; stp = st;
        @(negedge clk);
        chk("req_stall", {31'd0, stall}, 32'd1);
        chk("req_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        if (!ill) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                if (k == ack_dly) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = rword;
                end
                @(negedge clk);
                if (mif.mem_req === 1'b1) req_cycles++;
                chk("busy_stall", {31'd0, stall}, 32'd1);
                chk("busy_done", {31'd0, done}, 32'd0);
                chk("busy_we", {31'd0, mif.mem_we}, {31'd0, w});
                chk("busy_addr", {2'd0, mif.mem_addr}, {2'd0, a[31:2]});
                chk("busy_wstrb", {28'd0, mif.mem_wstrb}, w ? {28'd0, model_wstrb(st, a[1:0])} : 32'd0);
                if (w) chk("busy_wdata", mif.mem_wdata, model_wdata(st, d));
                if (k == 0) begin
                    last_wstrb = mif.mem_wstrb;
                    last_wdata = mif.mem_wdata;
                    last_maddr = mif.mem_addr;
                end
                @(posedge clk); #1;
                mif.mem_ack   = 1'b0;
                mif.mem_rdata = $urandom;
                if (k == ack_dly) break;
            end
            chk("req_cycles", 32'(req_cycles), tmo ? 32'(TIMEOUT) : 32'(ack_dly + 1));
        end else begin
            last_maddr = mif.mem_addr;
        end

        // DONE cycle: core retires here.
        @(negedge clk);
        got_ld = load_data;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, mif.mem_req}, 32'd0);
        chk("done_err", {31'd0, err}, {31'd0, (ill || tmo)});
        chk("done_code", {30'd0, err_code}, {30'd0, ecode});
        chk("done_ld", got_ld, exp_q.pop_front());
        last_ld         = got_ld;
        last_ecode      = err_code;
        last_req_cycles = req_cycles;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;

        // Idle cycle: pulses gone, load result held.
        @(negedge clk);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_ld_hold", load_data, exp_ld);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; ltp = 3'd0; stp = 2'd0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
        last_ld = '0; last_wstrb = '0; last_wdata = '0; last_maddr = '0;
        last_ecode = '0; last_req_cycles = 0;

        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst_addr", {2'd0, mif.mem_addr}, 32'd0);
        chk("rst_wstrb", {28'd0, mif.mem_wstrb}, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b1;
        @(posedge clk); #1;

        // LW 0x100, ack in first BUSY cycle.
        access(1'b1, 1'b0, 32'h100, 32'd0, 3'b101, 2'b00, 0, 32'hDEAD_BEEF);
        chk("lw_addr", {2'd0, last_maddr}, 32'h40);
        chk("lw_wstrb", {28'd0, last_wstrb}, 32'd0);
        chk("lw_data", last_ld, 32'hDEAD_BEEF);

        // Byte/half loads.
        access(1'b1, 1'b0, 32'h103, 32'd0, 3'b001, 2'b00, 1, 32'h8011_2233);
        chk("lb_data", last_ld, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 32'h103, 32'd0, 3'b010, 2'b00, 0, 32'h8011_2233);
        chk("lbu_data", last_ld, 32'h0000_0080);
        access(1'b1, 1'b0, 32'h102, 32'd0, 3'b100, 2'b00, 2, 32'h8011_2233);
        chk("lhu_data", last_ld, 32'h0000_8011);

        // Stores.
        access(1'b0, 1'b1, 32'h201, 32'h0000_00A5, 3'b000, 2'b01, 0, 32'd0);
        chk("sb_wstrb", {28'd0, last_wstrb}, 32'b0010);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        access(1'b0, 1'b1, 32'h202, 32'h0000_1234, 3'b000, 2'b10, 1, 32'd0);
        chk("sh_wstrb", {28'd0, last_wstrb}, 32'b1100);
        chk("sh_wdata", last_wdata, 32'h1234_1234);

        // Illegal requests.
        access(1'b1, 1'b0, 32'h102, 32'd0, 3'b101, 2'b00, 0, 32'd0);
        chk("mis_code", {30'd0, last_ecode}, 32'b01);
        access(1'b1, 1'b1, 32'h100, 32'h5, 3'b101, 2'b11, 0, 32'd0);
        chk("rw_code", {30'd0, last_ecode}, 32'b11);

        // Timeout, then a normal access; then ack exactly on expiry.
        access(1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 3'b000, 2'b11, 99, 32'd0);
        chk("tmo_code", {30'd0, last_ecode}, 32'b10);
        chk("tmo_req_cycles", 32'(last_req_cycles), 32'd4);
        access(1'b1, 1'b0, 32'h304, 32'd0, 3'b101, 2'b00, 1, 32'h1357_9BDF);
        chk("post_tmo_ld", last_ld, 32'h1357_9BDF);
        access(1'b1, 1'b0, 32'h308, 32'd0, 3'b011, 2'b00, TIMEOUT - 1, 32'h0000_F00F);
        chk("late_ack_ld", last_ld, 32'hFFFF_F00F);

        // Reset in BUSY, then a stray ack.
        rd = 1'b1; wr = 1'b0; addr = 32'h400; ltp = 3'b101;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, mif.mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("async_rst_state", 32'(state_dbg), 32'(IDLE));
        rd = 1'b0;
        @(negedge clk);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        mif.mem_ack = 1'b1;
        @(negedge clk);
        chk("stray_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_done", {31'd0, done}, 32'd0);
        chk("stray_state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk); #1;

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic        r;
            logic        w;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            r = (kind <= 5);
            w = (kind == 0) || (kind >= 6);
            a = {20'd0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            access(r, w, a, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, TIMEOUT + 1), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
